// File: rtl/arb_pkg.sv
// Shared types for the fetch/data memory-port arbiter: read-owner tags and flush helper.
// Pure declarations; no timing or backpressure of its own.
package arb_pkg;

  localparam int MEM_LAT_MAX = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } arb_tag_t;

  localparam arb_tag_t TAG_NONE = '{valid: 1'b0, owner: OWN_NONE};

  // A flush drops instruction-owned reads only; data reads must still complete.
  function automatic arb_tag_t kill_inst(arb_tag_t t, logic flush);
    arb_tag_t r;
    r = t;
    if (flush && t.owner == OWN_INST) r = TAG_NONE;
    return r;
  endfunction

endpackage

// File: rtl/arb_tag_pipe.sv
// Owner-tag delay line matching the memory read latency; last stage is combinationally flush-masked.
// Latency DEPTH cycles from push to last; never stalls, one entry shifted in every cycle.
module arb_tag_pipe
  import arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  arb_tag_t push,
  input  logic     flush_inst,
  output arb_tag_t last
);

  if (DEPTH < 1 || DEPTH > MEM_LAT_MAX) begin : g_bad_depth
    $error("arb_tag_pipe: DEPTH out of range 1..MEM_LAT_MAX");
  end

  arb_tag_t stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= TAG_NONE;
    end else begin
      stage[0] <= kill_inst(push, flush_inst);
      for (int i = 1; i < DEPTH; i++) stage[i] <= kill_inst(stage[i-1], flush_inst);
    end
  end

  // A fetch arriving in the flush cycle itself must not be delivered either.
  assign last = kill_inst(stage[DEPTH-1], flush_inst);

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter onto one single-ported memory; combinational grant, responses MEM_LAT cycles later.
// Loser is held off via gnt=0 (stall_if for fetch); `ARB_PERF_CNT_EN adds conflict/forced-grant counters.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter  int ADDR_W     = 32,
  parameter  int DATA_W     = 32,
  parameter  int MEM_LAT    = 1,
  parameter  int STARVE_MAX = 4,
  localparam int BE_W       = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              stall_if,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [BE_W-1:0]   d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [BE_W-1:0]   m_be,
  input  logic [DATA_W-1:0] m_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_conflict_cnt,
  output logic [31:0]       perf_force_cnt
`endif
);

  localparam int SC_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);

  logic            eff_if;
  logic            both_req;
  logic            force_if;
  logic [SC_W-1:0] starve_cnt;
  arb_tag_t        push_tag;
  arb_tag_t        last_tag;

  // Gating with rst_n keeps every output at zero while reset is asserted.
  assign eff_if   = rst_n & if_req & ~if_flush;
  assign both_req = eff_if & d_req;
  assign force_if = both_req & (STARVE_MAX != 0) & (starve_cnt == SC_MAX);
  assign if_gnt   = eff_if & (~d_req | force_if);
  assign d_gnt    = rst_n & d_req & ~force_if;
  assign stall_if = rst_n & if_req & ~if_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!eff_if || if_gnt) begin
      starve_cnt <= '0;
    end else if (d_req && starve_cnt != SC_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_comb begin
    m_req   = if_gnt | d_gnt;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_be    = '0;
    if (if_gnt) begin
      m_addr = if_addr;
      m_be   = '1;
    end else if (d_gnt) begin
      m_we    = d_we;
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_be    = d_be;
    end
  end

  always_comb begin
    push_tag = TAG_NONE;
    if (if_gnt)              push_tag = '{valid: 1'b1, owner: OWN_INST};
    else if (d_gnt && !d_we) push_tag = '{valid: 1'b1, owner: OWN_DATA};
  end

  arb_tag_pipe #(.DEPTH(MEM_LAT)) u_tag_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_tag),
    .flush_inst (if_flush),
    .last       (last_tag)
  );

  assign if_rvalid = last_tag.valid & (last_tag.owner == OWN_INST);
  assign d_rvalid  = last_tag.valid & (last_tag.owner == OWN_DATA);
  assign if_rdata  = if_rvalid ? m_rdata : '0;
  assign d_rdata   = d_rvalid  ? m_rdata : '0;

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_conflict_cnt <= '0;
      perf_force_cnt    <= '0;
    end else begin
      if (both_req) perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      if (force_if) perf_force_cnt    <= perf_force_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT 1,2,3) share stimulus, each with its own memory.
module tb_mem_port_arbiter;

  localparam int NI   = 3;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_flush, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_be;

  logic        ig [NI], irv [NI], st [NI], dg [NI], drv [NI], mrq [NI], mwe [NI];
  logic [31:0] ird [NI], drd [NI], madr [NI], mwd [NI], mrd [NI];
  logic [3:0]  mbe [NI];
`ifdef ARB_PERF_CNT_EN
  logic [31:0] pcc [NI], pfc [NI];
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  for (genvar k = 0; k < NI; k++) begin : g_dut
    mem_port_arbiter #(.MEM_LAT(k + 1), .STARVE_MAX(SMAX)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_gnt(ig[k]), .if_rvalid(irv[k]), .if_rdata(ird[k]), .stall_if(st[k]),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(dg[k]), .d_rvalid(drv[k]), .d_rdata(drd[k]),
      .m_req(mrq[k]), .m_we(mwe[k]), .m_addr(madr[k]), .m_wdata(mwd[k]), .m_be(mbe[k]),
      .m_rdata(mrd[k])
`ifdef ARB_PERF_CNT_EN
      , .perf_conflict_cnt(pcc[k]), .perf_force_cnt(pfc[k])
`endif
    );

    // Memory environment: 128 words, reinitialised while reset is held, junk when no read.
    logic [31:0] mem [128];
    logic [31:0] rdp [NI];
    always @(posedge clk) begin : p_env
      logic [31:0] w;
      w = mem[madr[k][8:2]];
      rdp[0] <= (mrq[k] && !mwe[k]) ? w : 32'h5A5A_5A5A;
      for (int i = 1; i < NI; i++) rdp[i] <= rdp[i-1];
      if (!rst_n) begin
        for (int i = 0; i < 128; i++) mem[i] <= init_word(i);
      end else if (mrq[k] && mwe[k]) begin
        for (int b = 0; b < 4; b++) if (mbe[k][b]) w[8*b +: 8] = mwd[k][8*b +: 8];
        mem[madr[k][8:2]] <= w;
      end
    end
    assign mrd[k] = rdp[k];
  end

  task automatic chk1(input string nm, input int k, input logic act, input logic exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s[lat%0d] cyc%0d: actual=%b required=%b", nm, k + 1, cyc, act, exp_v);
    end
  endtask

  task automatic chk32(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s[lat%0d] cyc%0d: actual=%h required=%h", nm, k + 1, cyc, act, exp_v);
    end
  endtask

  task automatic chk_core(input int k, input logic eig, input logic edg, input logic est,
                          input logic ewe, input logic [3:0] ebe, input logic [31:0] ea,
                          input logic [31:0] ewd);
    chk1("if_gnt", k, ig[k], eig);
    chk1("d_gnt", k, dg[k], edg);
    chk1("stall_if", k, st[k], est);
    chk1("m_req", k, mrq[k], eig | edg);
    chk1("m_we", k, mwe[k], ewe);
    chk32("m_be", k, {28'd0, mbe[k]}, {28'd0, ebe});
    chk32("m_addr", k, madr[k], ea);
    chk32("m_wdata", k, mwd[k], ewd);
  endtask

  task automatic chk_resp(input int k, input logic eirv, input logic [31:0] eird,
                          input logic edrv, input logic [31:0] edrd);
    chk1("if_rvalid", k, irv[k], eirv);
    chk32("if_rdata", k, ird[k], eird);
    chk1("d_rvalid", k, drv[k], edrv);
    chk32("d_rdata", k, drd[k], edrd);
  endtask

  task automatic set_in(input logic ir, input logic fl, input logic dr, input logic we,
                        input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                        input logic [3:0] be);
    @(negedge clk);
    if_req = ir; if_flush = fl; d_req = dr; d_we = we;
    if_addr = ia; d_addr = da; d_wdata = wd; d_be = be;
    #2;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        ir, fl, dr, we;
    logic [31:0] ia, da, wd;
    logic [3:0]  be;
    logic        eig, edg, est, eirv, edrv;
    logic [31:0] erd;
  } vec_t;

  function automatic vec_t mk(logic ir, logic fl, logic dr, logic we,
                              logic [31:0] ia, logic [31:0] da, logic [31:0] wd, logic [3:0] be,
                              logic eig, logic edg, logic est, logic eirv, logic edrv,
                              logic [31:0] erd);
    vec_t v;
    v.ir = ir; v.fl = fl; v.dr = dr; v.we = we; v.ia = ia; v.da = da; v.wd = wd; v.be = be;
    v.eig = eig; v.edg = edg; v.est = est; v.eirv = eirv; v.edrv = edrv; v.erd = erd;
    return v;
  endfunction

  typedef struct {
    int          issue;
    bit          inst;
    logic [31:0] data;
    bit [NI-1:0] killed;
  } pend_t;

  initial begin
    vec_t        tbl [18];
    pend_t       pend [$];
    logic [31:0] ref_mem [128];
    int          starve, n_conf, n_force;
    logic        ir, fl, dr, we, eff, fw, dw, eirv, edrv;
    logic [31:0] ia, da, wd, eird, edrd, w;
    logic [3:0]  be;

    // Response columns refer to the MEM_LAT=1 instance.
    tbl[0]  = mk(1,0,0,0, 32'h0, 32'h0,   32'h0,         4'hF, 1,0,0, 0,0, 32'h0);
    tbl[1]  = mk(1,0,0,0, 32'h4, 32'h0,   32'h0,         4'hF, 1,0,0, 1,0, 32'h1000_0000);
    tbl[2]  = mk(1,0,0,0, 32'h8, 32'h0,   32'h0,         4'hF, 1,0,0, 1,0, 32'h1000_0001);
    tbl[3]  = mk(0,0,0,0, 32'h0, 32'h0,   32'h0,         4'h0, 0,0,0, 1,0, 32'h1000_0002);
    tbl[4]  = mk(1,0,1,0, 32'hC, 32'h20,  32'h0,         4'hF, 0,1,1, 0,0, 32'h0);
    tbl[5]  = mk(1,0,1,0, 32'hC, 32'h20,  32'h0,         4'hF, 0,1,1, 0,1, 32'h1000_0008);
    tbl[6]  = mk(1,0,1,0, 32'hC, 32'h20,  32'h0,         4'hF, 0,1,1, 0,1, 32'h1000_0008);
    tbl[7]  = mk(1,0,1,0, 32'hC, 32'h20,  32'h0,         4'hF, 0,1,1, 0,1, 32'h1000_0008);
    tbl[8]  = mk(1,0,1,0, 32'hC, 32'h20,  32'h0,         4'hF, 1,0,0, 0,1, 32'h1000_0008);
    tbl[9]  = mk(1,0,1,0, 32'hC, 32'h20,  32'h0,         4'hF, 0,1,1, 1,0, 32'h1000_0003);
    tbl[10] = mk(0,0,0,0, 32'h0, 32'h0,   32'h0,         4'h0, 0,0,0, 0,1, 32'h1000_0008);
    tbl[11] = mk(0,0,1,1, 32'h0, 32'h100, 32'hDEADBEEF,  4'h3, 0,1,0, 0,0, 32'h0);
    tbl[12] = mk(0,0,1,0, 32'h0, 32'h100, 32'h0,         4'hF, 0,1,0, 0,0, 32'h0);
    tbl[13] = mk(0,0,0,0, 32'h0, 32'h0,   32'h0,         4'h0, 0,0,0, 0,1, 32'h1000_BEEF);
    tbl[14] = mk(1,1,0,0, 32'h10, 32'h0,  32'h0,         4'h0, 0,0,1, 0,0, 32'h0);
    tbl[15] = mk(1,1,1,0, 32'h10, 32'h24, 32'h0,         4'hF, 0,1,1, 0,0, 32'h0);
    tbl[16] = mk(1,0,1,0, 32'h10, 32'h24, 32'h0,         4'hF, 0,1,1, 0,1, 32'h1000_0009);
    tbl[17] = mk(0,0,0,0, 32'h0, 32'h0,   32'h0,         4'h0, 0,0,0, 0,1, 32'h1000_0009);

    rst_n = 1'b0;
    if_req = 0; if_flush = 0; d_req = 0; d_we = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0;

    // Reset state, with requests asserted to prove grants are suppressed.
    @(negedge clk);
    if_req = 1; d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h44;
    #2;
    for (int k = 0; k < NI; k++) begin
      chk_core(k, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
      chk_resp(k, 0, 32'h0, 0, 32'h0);
    end
    if_req = 0; d_req = 0; d_we = 0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 18; r++) begin
      vec_t v;
      v = tbl[r];
      cyc = r;
      set_in(v.ir, v.fl, v.dr, v.we, v.ia, v.da, v.wd, v.be);
      for (int k = 0; k < NI; k++)
        chk_core(k, v.eig, v.edg, v.est, v.edg & v.we,
                 v.eig ? 4'hF : (v.edg ? v.be : 4'h0),
                 v.eig ? v.ia : (v.edg ? v.da : 32'h0),
                 v.edg ? v.wd : 32'h0);
      chk_resp(0, v.eirv, v.eirv ? v.erd : 32'h0, v.edrv, v.edrv ? v.erd : 32'h0);
    end

    // MEM_LAT=3: fetch, data read, fetch -> responses at +3 in issue order.
    repeat (4) idle();
    cyc = 100;
    set_in(1,0,0,0, 32'h8, 32'h0, 32'h0, 4'hF);  chk1("s1_if_gnt", 2, ig[2], 1'b1);
    set_in(0,0,1,0, 32'h0, 32'h20, 32'h0, 4'hF); chk1("s1_d_gnt", 2, dg[2], 1'b1);
    chk_resp(2, 0, 32'h0, 0, 32'h0);
    set_in(1,0,0,0, 32'h4, 32'h0, 32'h0, 4'hF);  chk_resp(2, 0, 32'h0, 0, 32'h0);
    idle(); chk_resp(2, 1, 32'h1000_0002, 0, 32'h0);
    idle(); chk_resp(2, 0, 32'h0, 1, 32'h1000_0008);
    idle(); chk_resp(2, 1, 32'h1000_0001, 0, 32'h0);

    // Flush kills the in-flight fetch on every latency, data read survives.
    repeat (4) idle();
    cyc = 200;
    set_in(1,0,0,0, 32'h4, 32'h0, 32'h0, 4'hF);
    set_in(1,1,1,0, 32'h8, 32'h20, 32'h0, 4'hF);
    chk1("s2_if_gnt", 1, ig[1], 1'b0);
    chk1("s2_d_gnt", 1, dg[1], 1'b1);
    chk1("s2_flush_last", 0, irv[0], 1'b0);
    idle(); chk_resp(1, 0, 32'h0, 0, 32'h0); chk_resp(0, 0, 32'h0, 1, 32'h1000_0008);
    idle(); chk_resp(1, 0, 32'h0, 1, 32'h1000_0008);
    repeat (2) idle(); chk_resp(2, 0, 32'h0, 0, 32'h0);

    // Reset with two reads in flight.
    cyc = 300;
    set_in(1,0,0,0, 32'h0, 32'h0, 32'h0, 4'hF);
    set_in(0,0,1,0, 32'h0, 32'h20, 32'h0, 4'hF);
    @(negedge clk);
    rst_n = 1'b0; if_req = 1; d_req = 1; d_we = 1;
    #2;
    for (int k = 0; k < NI; k++) begin
      chk_core(k, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
      chk_resp(k, 0, 32'h0, 0, 32'h0);
`ifdef ARB_PERF_CNT_EN
      chk32("perf_conflict_rst", k, pcc[k], 32'h0);
      chk32("perf_force_rst", k, pfc[k], 32'h0);
`endif
    end
    @(negedge clk);
    if_req = 0; d_req = 0; d_we = 0;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      idle();
      for (int k = 0; k < NI; k++) chk_resp(k, 0, 32'h0, 0, 32'h0);
    end

    // Randomised phase against a transaction-level model.
    do_reset();
    for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
    starve = 0; n_conf = 0; n_force = 0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      ir = ($urandom_range(0, 9) < 7);
      fl = ($urandom_range(0, 9) == 0);
      dr = ($urandom_range(0, 9) < 6);
      we = ($urandom_range(0, 9) < 3);
      ia = $urandom; da = $urandom; wd = $urandom; be = 4'($urandom);
      set_in(ir, fl, dr, we, ia, da, wd, be);

      eff = ir && !fl;
      if (eff && dr) fw = (starve == SMAX);
      else           fw = eff;
      dw = dr && !fw;
      if (eff && dr) n_conf++;
      if (eff && dr && fw) n_force++;

      if (fl)
        foreach (pend[j])
          if (pend[j].inst)
            for (int k = 0; k < NI; k++)
              if (pend[j].issue + k + 1 >= cyc) pend[j].killed[k] = 1'b1;

      for (int k = 0; k < NI; k++) begin
        eirv = 0; edrv = 0; eird = 0; edrd = 0;
        foreach (pend[j])
          if (pend[j].issue + k + 1 == cyc && !pend[j].killed[k]) begin
            if (pend[j].inst) begin eirv = 1; eird = pend[j].data; end
            else              begin edrv = 1; edrd = pend[j].data; end
          end
        chk_core(k, fw, dw, ir && !fw, dw && we,
                 fw ? 4'hF : (dw ? be : 4'h0),
                 fw ? ia : (dw ? da : 32'h0),
                 dw ? wd : 32'h0);
        chk_resp(k, eirv, eird, edrv, edrd);
      end

      if (fw) pend.push_back('{issue: cyc, inst: 1'b1, data: ref_mem[ia[8:2]], killed: '0});
      else if (dw && !we) pend.push_back('{issue: cyc, inst: 1'b0, data: ref_mem[da[8:2]], killed: '0});
      if (dw && we) begin
        w = ref_mem[da[8:2]];
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
        ref_mem[da[8:2]] = w;
      end
      if (eff && dr && !fw) starve = (starve < SMAX) ? starve + 1 : starve;
      else                  starve = 0;
      while (pend.size() > 0 && pend[0].issue + NI < cyc + 1) void'(pend.pop_front());
    end

`ifdef ARB_PERF_CNT_EN
    idle();
    for (int k = 0; k < NI; k++) begin
      chk32("perf_conflict", k, pcc[k], 32'(n_conf));
      chk32("perf_force", k, pfc[k], 32'(n_force));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
